pass_error_reader: RTL and testbench
====================================

Name: pass_error_reader

Overview:
- Consumer-side end of the per-bit-plane pass distortion interface.
- Captures the three parallel pass errors (SP, MRP, CP) that the distortion calculator produces once per bit plane, and buffers them.
- Emits them as a pass-ordered serial stream with ready/valid handshake toward rate control (PCRD truncation).
- Attaches pass type, pass index within the code-block and running cumulative distortion to every pass.

Parameters:
- ERR_W, 31, width of each incoming pass error word
- CUM_W, 36, width of cumulative distortion output
- DEPTH, 4, bit-plane entries buffered (power of two)
- IDX_W, 6, pass index width (max 46 passes per code-block)

Ports:
- clk  in  1  single block clock
- rst  in  1  asynchronous reset, active-low
- rst_syn  in  1  synchronous clear, active-high; same effect as rst
- pass_error_sp  in  ERR_W  significance-propagation pass distortion
- pass_error_mrp  in  ERR_W  magnitude-refinement pass distortion
- pass_error_cp  in  ERR_W  cleanup pass distortion
- pass_error_vld  in  1  one-cycle strobe: the three words and qualifiers are final for one bit plane
- count_bp  in  4  bit-plane number of the strobed plane
- first_bp  in  1  qualifier: first coded plane; only CP exists
- last_bp  in  1  qualifier: last plane of the code-block
- pass_out_rdy  in  1  downstream ready
- pass_out_vld  out  1  output pass valid
- pass_dist_out  out  ERR_W  distortion of this pass
- pass_type_out  out  2  0=SP, 1=MRP, 2=CP
- pass_bp_out  out  4  bit plane of this pass
- pass_idx_out  out  IDX_W  pass index in code-block, first pass = 0
- cum_dist_out  out  CUM_W  saturating sum of distortion of passes 0..current
- pass_last_out  out  1  final pass of the code-block
- ovf_err  out  1  sticky: a strobe was dropped on a full buffer

Behaviour:
- Reset: rst low, or rst_syn high at an edge, zeroes all outputs, empties the buffer, sets the FSM to IDLE and clears the index/accumulator. This applies mid-emission; the partial block is discarded.
- Capture: on pass_error_vld, write {sp, mrp, cp, count_bp, first_bp, last_bp} into the FIFO.
  - Write is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and ovf_err is set until reset.
- FSM states: IDLE, EMIT_SP, EMIT_MRP, EMIT_CP.
  - IDLE, FIFO non-empty: load head; go to EMIT_CP if first_bp, else EMIT_SP.
  - EMIT_SP -> EMIT_MRP, and EMIT_MRP -> EMIT_CP, each on a vld&rdy handshake.
  - EMIT_CP on handshake: pop head. If the FIFO holds another entry, load it with no bubble cycle. Otherwise go to IDLE.
- Outputs are registered. pass_out_vld is high in all EMIT states. All outputs stay stable while vld && !rdy.
- Latency from IDLE with empty FIFO: pass_out_vld rises at the second rising edge after the edge that samples pass_error_vld.
- Throughput: one pass per cycle while rdy is held high.
- pass_idx_out / cum_dist_out:
  - Both update with the pass being presented.
  - cum = previous cum + zero-extended pass distortion, saturating at 2^CUM_W-1.
  - Index increments per handshake and never wraps in legal use.
- pass_last_out is 1 only on the CP pass of an entry with last_bp=1.
  - After that handshake, the index and accumulator clear to 0 for the next code-block.
- An entry with first_bp=1 also restarts the index and accumulator at 0, which guards against a missing last_bp.
- Zero-valued distortions are emitted normally and never skipped.

Decomposition:
- Shared package pass_err_pkg:
  - pass type codes PASS_SP/PASS_MRP/PASS_CP
  - ERR_W and CUM_W constants
  - FSM state encoding
- One sub-module, pass_error_fifo:
  - synchronous FIFO, DEPTH x (3*ERR_W+6)
  - full/empty flags, simultaneous push/pop when full supported
  - async active-low reset plus rst_syn
- The top holds the FSM, index counter and saturating accumulator.

Test Plan:
- Strobe first_bp=1, cp=100, rdy=1 -> exactly one output: type 2, idx 0, cum 100, last 0.
- Then strobe sp=10, mrp=20, cp=30, last_bp=1 -> idx 1,2,3, types 0,1,2, cum 110,130,160; last=1 only on idx 3. The next first_bp plane restarts at idx 0, cum equal to its cp.
- Hold rdy=0 for 5 cycles mid-plane -> pass_out_vld and all data stay constant; after release, passes complete in order with none lost or duplicated.
- 5 strobes back-to-back with rdy=0, DEPTH=4 -> ovf_err=1, fifth plane absent from the output. The first four emit correctly, and ovf_err stays 1 until rst_syn.
- Feed 33 passes of 0x7FFFFFFF within one block -> cum_dist_out clamps at 0xFFFFFFFFF and holds; the next block starts from 0.
- Assert rst low during EMIT_MRP -> all outputs 0 immediately and FIFO empty. A fresh strobe after release yields idx 0. Repeat with rst_syn: clear takes effect at the next edge.

Source files
------------

// File: rtl/pass_err_pkg.sv
// Shared types for the pass distortion reader: pass type codes, word widths
// and the emitter FSM encoding.
package pass_err_pkg;

  localparam int PE_ERR_W = 31;
  localparam int PE_CUM_W = 36;

  typedef enum logic [1:0] {
    PASS_SP  = 2'd0,
    PASS_MRP = 2'd1,
    PASS_CP  = 2'd2
  } pass_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_SP  = 2'd1,
    ST_EMIT_MRP = 2'd2,
    ST_EMIT_CP  = 2'd3
  } state_e;

endpackage

// File: rtl/pass_error_fifo.sv
// Bit-plane entry FIFO. Exposes the head and the entry behind it so the
// emitter can chain planes without a bubble.
module pass_error_fifo #(
  parameter int W     = 99,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rst_syn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] nxt,
  output logic         full,
  output logic         empty,
  output logic         more
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk)
    if (push) mem[wp] <= din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (rst_syn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rp];
  assign nxt   = mem[rp + 1'b1];
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign more  = (cnt > (AW+1)'(1));

endmodule

// File: rtl/pass_error_reader.sv
// Buffers per-bit-plane SP/MRP/CP distortions and serialises them in pass order
// with pass index and saturating cumulative distortion toward rate control.
module pass_error_reader
  import pass_err_pkg::*;
#(
  parameter int ERR_W = PE_ERR_W,
  parameter int CUM_W = PE_CUM_W,
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_syn,
  input  logic [ERR_W-1:0] pass_error_sp,
  input  logic [ERR_W-1:0] pass_error_mrp,
  input  logic [ERR_W-1:0] pass_error_cp,
  input  logic             pass_error_vld,
  input  logic [3:0]       count_bp,
  input  logic             first_bp,
  input  logic             last_bp,
  input  logic             pass_out_rdy,
  output logic             pass_out_vld,
  output logic [ERR_W-1:0] pass_dist_out,
  output logic [1:0]       pass_type_out,
  output logic [3:0]       pass_bp_out,
  output logic [IDX_W-1:0] pass_idx_out,
  output logic [CUM_W-1:0] cum_dist_out,
  output logic             pass_last_out,
  output logic             ovf_err
);
  // Entry layout: {sp, mrp, cp, bp[3:0], first, last}
  localparam int ENT_W = 3*ERR_W + 6;

  logic             cap_vld;
  logic [ENT_W-1:0] cap_ent, head_ent, nxt_ent, ld_ent;
  logic             fifo_full, fifo_empty, fifo_more;
  logic             push, pop, hs;
  state_e           state;
  logic             blk_start;

  // Input capture stage: the strobe is registered before entering the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_vld <= 1'b0;
      cap_ent <= '0;
    end else if (rst_syn) begin
      cap_vld <= 1'b0;
      cap_ent <= '0;
    end else begin
      cap_vld <= pass_error_vld;
      if (pass_error_vld)
        cap_ent <= {pass_error_sp, pass_error_mrp, pass_error_cp, count_bp, first_bp, last_bp};
    end
  end

  assign hs   = pass_out_vld && pass_out_rdy;
  assign pop  = hs && (state == ST_EMIT_CP);
  assign push = cap_vld && (!fifo_full || pop);

  pass_error_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .rst_syn(rst_syn),
    .push(push), .din(cap_ent), .pop(pop),
    .head(head_ent), .nxt(nxt_ent),
    .full(fifo_full), .empty(fifo_empty), .more(fifo_more)
  );

  logic             ld, ld_new, restart;
  pass_type_e       ld_type;
  logic [ERR_W-1:0] ld_dist;
  logic [CUM_W:0]   cum_sum;
  logic [IDX_W-1:0] nxt_idx;
  logic [CUM_W-1:0] nxt_cum;

  always_comb begin
    ld      = 1'b0;
    ld_new  = 1'b0;
    ld_ent  = head_ent;
    ld_type = PASS_SP;
    ld_dist = '0;
    case (state)
      ST_IDLE:     if (!fifo_empty) begin ld = 1'b1; ld_new = 1'b1; end
      ST_EMIT_SP:  if (hs) begin ld = 1'b1; ld_type = PASS_MRP; end
      ST_EMIT_MRP: if (hs) begin ld = 1'b1; ld_type = PASS_CP; end
      ST_EMIT_CP:  if (hs && fifo_more) begin ld = 1'b1; ld_new = 1'b1; ld_ent = nxt_ent; end
      default: ;
    endcase
    if (ld_new) ld_type = ld_ent[1] ? PASS_CP : PASS_SP;
    case (ld_type)
      PASS_SP:  ld_dist = ld_ent[ENT_W-1 -: ERR_W];
      PASS_MRP: ld_dist = ld_ent[ENT_W-1-ERR_W -: ERR_W];
      default:  ld_dist = ld_ent[ERR_W+5 -: ERR_W];
    endcase
    // A new code-block starts after reset, after a last CP, or on a first plane.
    restart = blk_start || (hs && pass_last_out) || (ld_new && ld_ent[1]);
    cum_sum = {1'b0, cum_dist_out} + (CUM_W+1)'(ld_dist);
    nxt_idx = restart ? '0 : pass_idx_out + 1'b1;
    nxt_cum = restart ? CUM_W'(ld_dist) : (cum_sum[CUM_W] ? '1 : cum_sum[CUM_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;        blk_start <= 1'b1;    ovf_err <= 1'b0;
      pass_out_vld <= 1'b0;    pass_dist_out <= '0;  pass_type_out <= '0;
      pass_bp_out <= '0;       pass_idx_out <= '0;   cum_dist_out <= '0;
      pass_last_out <= 1'b0;
    end else if (rst_syn) begin
      state <= ST_IDLE;        blk_start <= 1'b1;    ovf_err <= 1'b0;
      pass_out_vld <= 1'b0;    pass_dist_out <= '0;  pass_type_out <= '0;
      pass_bp_out <= '0;       pass_idx_out <= '0;   cum_dist_out <= '0;
      pass_last_out <= 1'b0;
    end else begin
      if (cap_vld && !push) ovf_err <= 1'b1;
      if (ld) begin
        state <= (ld_type == PASS_SP)  ? ST_EMIT_SP :
                 (ld_type == PASS_MRP) ? ST_EMIT_MRP : ST_EMIT_CP;
        pass_out_vld  <= 1'b1;
        pass_dist_out <= ld_dist;
        pass_type_out <= ld_type;
        pass_bp_out   <= ld_ent[5:2];
        pass_idx_out  <= nxt_idx;
        cum_dist_out  <= nxt_cum;
        pass_last_out <= (ld_type == PASS_CP) && ld_ent[0];
        blk_start     <= 1'b0;
      end else if (hs) begin
        state         <= ST_IDLE;
        pass_out_vld  <= 1'b0;
        pass_last_out <= 1'b0;
        if (pass_last_out) begin
          pass_idx_out <= '0;
          cum_dist_out <= '0;
          blk_start    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pass_error_reader.sv
// Directed bench for pass_error_reader with a pass-order scoreboard.
module tb_pass_error_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_syn = 1'b0;
  logic [30:0] pass_error_sp = '0, pass_error_mrp = '0, pass_error_cp = '0;
  logic        pass_error_vld = 1'b0;
  logic [3:0]  count_bp = '0;
  logic        first_bp = 1'b0, last_bp = 1'b0;
  logic        pass_out_rdy = 1'b1;
  logic        pass_out_vld;
  logic [30:0] pass_dist_out;
  logic [1:0]  pass_type_out;
  logic [3:0]  pass_bp_out;
  logic [5:0]  pass_idx_out;
  logic [35:0] cum_dist_out;
  logic        pass_last_out;
  logic        ovf_err;

  pass_error_reader dut (
    .clk(clk), .rst(rst), .rst_syn(rst_syn),
    .pass_error_sp(pass_error_sp), .pass_error_mrp(pass_error_mrp), .pass_error_cp(pass_error_cp),
    .pass_error_vld(pass_error_vld), .count_bp(count_bp), .first_bp(first_bp), .last_bp(last_bp),
    .pass_out_rdy(pass_out_rdy), .pass_out_vld(pass_out_vld), .pass_dist_out(pass_dist_out),
    .pass_type_out(pass_type_out), .pass_bp_out(pass_bp_out), .pass_idx_out(pass_idx_out),
    .cum_dist_out(cum_dist_out), .pass_last_out(pass_last_out), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [79:0] sb [$];
  logic [5:0]  m_idx = '0;
  logic [35:0] m_cum = '0;
  bit          m_new = 1'b1;
  logic [35:0] last_cum = '0;
  logic [80:0] snap;
  logic [79:0] out_vec;

  assign out_vec = {pass_dist_out, pass_type_out, pass_bp_out, pass_idx_out, cum_dist_out, pass_last_out};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_pass(input logic [30:0] d, input logic [1:0] t, input logic [3:0] bp,
                            input logic lst, input bit rs);
    logic [36:0] s;
    if (rs || m_new) begin
      m_idx = '0;
      m_cum = {5'b0, d};
    end else begin
      m_idx = m_idx + 6'd1;
      s = {1'b0, m_cum} + {6'b0, d};
      m_cum = s[36] ? 36'hFFFFFFFFF : s[35:0];
    end
    sb.push_back({d, t, bp, m_idx, m_cum, lst});
    m_new = lst;
  endtask

  task automatic strobe(input logic [30:0] sp, input logic [30:0] mrp, input logic [30:0] cp,
                        input logic [3:0] bp, input logic fb, input logic lb, input bit keep = 1'b1);
    pass_error_sp = sp; pass_error_mrp = mrp; pass_error_cp = cp;
    count_bp = bp; first_bp = fb; last_bp = lb; pass_error_vld = 1'b1;
    @(posedge clk); #1;
    pass_error_vld = 1'b0;
    if (keep) begin
      if (fb) model_pass(cp, 2'd2, bp, lb, 1'b1);
      else begin
        model_pass(sp,  2'd0, bp, 1'b0, 1'b0);
        model_pass(mrp, 2'd1, bp, 1'b0, 1'b0);
        model_pass(cp,  2'd2, bp, lb,   1'b0);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || pass_out_vld) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 96'(sb.size()), 96'd0);
  endtask

  task automatic model_clear();
    sb.delete();
    m_new = 1'b1;
  endtask

  // Every handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst && !rst_syn && pass_out_vld && pass_out_rdy) begin
      last_cum = cum_dist_out;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pass observed=%0h required=none", out_vec);
      end else begin
        chk("pass", 96'(out_vec), 96'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("reset_out", {pass_out_vld, ovf_err, out_vec}, 96'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // First plane only carries CP; check latency of two edges.
    strobe(31'd0, 31'd0, 31'd100, 4'd9, 1'b1, 1'b0);
    @(negedge clk); chk("lat_e0", 96'(pass_out_vld), 96'd0);
    @(negedge clk); chk("lat_e1", 96'(pass_out_vld), 96'd0);
    @(negedge clk); chk("lat_e2", 96'(pass_out_vld), 96'd1);
    wait_drain("drain_first");

    strobe(31'd10, 31'd20, 31'd30, 4'd8, 1'b0, 1'b1);
    wait_drain("drain_last");
    strobe(31'd0, 31'd0, 31'd7, 4'd7, 1'b1, 1'b0);
    wait_drain("drain_restart");

    // Stall mid-plane on the MRP pass.
    pass_out_rdy = 1'b0;
    strobe(31'd11, 31'd12, 31'd13, 4'd6, 1'b0, 1'b0);
    strobe(31'd21, 31'd22, 31'd23, 4'd5, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    pass_out_rdy = 1'b1;
    @(posedge clk); #1;
    pass_out_rdy = 1'b0;
    @(negedge clk);
    snap = {pass_out_vld, out_vec};
    chk("stall_type", 96'(pass_type_out), 96'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", 96'({pass_out_vld, out_vec}), 96'(snap));
    end
    @(posedge clk); #1;
    pass_out_rdy = 1'b1;
    wait_drain("drain_stall");

    // Five planes into a four-deep buffer with the consumer blocked.
    pass_out_rdy = 1'b0;
    strobe(31'd0, 31'd0, 31'd1, 4'd9, 1'b1, 1'b0);
    strobe(31'd2, 31'd3, 31'd4, 4'd8, 1'b0, 1'b0);
    strobe(31'd5, 31'd6, 31'd7, 4'd7, 1'b0, 1'b0);
    strobe(31'd8, 31'd9, 31'd10, 4'd6, 1'b0, 1'b1);
    strobe(31'd99, 31'd99, 31'd99, 4'd5, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("ovf_set", 96'(ovf_err), 96'd1);
    pass_out_rdy = 1'b1;
    wait_drain("drain_ovf");
    chk("ovf_sticky", 96'(ovf_err), 96'd1);
    rst_syn = 1'b1;
    @(posedge clk); #1;
    rst_syn = 1'b0;
    model_clear();
    chk("ovf_clear", 96'(ovf_err), 96'd0);

    // Saturation: 34 passes of the maximum error word in one block.
    strobe(31'd0, 31'd0, 31'h7FFFFFFF, 4'd12, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      strobe(31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 4'(11 - i), 1'b0, (i == 10));
      repeat (2) @(posedge clk); #1;
    end
    wait_drain("drain_sat");
    chk("sat_clamp", 96'(last_cum), 96'h0_FFFF_FFFF_F);
    strobe(31'd0, 31'd0, 31'd5, 4'd3, 1'b1, 1'b0);
    wait_drain("drain_after_sat");

    // Asynchronous reset while presenting MRP.
    pass_out_rdy = 1'b0;
    strobe(31'd1, 31'd2, 31'd3, 4'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    pass_out_rdy = 1'b1;
    @(posedge clk); #1;
    pass_out_rdy = 1'b0;
    chk("pre_rst_type", 96'(pass_type_out), 96'd1);
    #2 rst = 1'b0;
    #1 chk("async_rst_out", {pass_out_vld, ovf_err, out_vec}, 96'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    pass_out_rdy = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("fifo_empty_rst", 96'(pass_out_vld), 96'd0);
    strobe(31'd5, 31'd6, 31'd7, 4'd2, 1'b0, 1'b0);
    wait_drain("drain_post_rst");

    // Synchronous clear while presenting MRP.
    pass_out_rdy = 1'b0;
    strobe(31'd8, 31'd9, 31'd10, 4'd1, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    pass_out_rdy = 1'b1;
    @(posedge clk); #1;
    pass_out_rdy = 1'b0;
    rst_syn = 1'b1;
    @(negedge clk);
    chk("syn_pre_edge", 96'(pass_out_vld), 96'd1);
    @(posedge clk); #1;
    rst_syn = 1'b0;
    chk("syn_post_edge", {pass_out_vld, pass_idx_out, cum_dist_out}, 96'd0);
    model_clear();
    pass_out_rdy = 1'b1;
    strobe(31'd1, 31'd2, 31'd3, 4'd0, 1'b0, 1'b1);
    wait_drain("drain_post_syn");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
